// File: rtl/ym3438_dbg_pkg.sv
// ym3438_dbg_pkg
// Shared definitions for the debug serial read-chain capture logic.
//   DBG_WORD_W   : default word width shifted out of the dbg_read chain
//   dbg_state_t  : deserializer state encoding
package ym3438_dbg_pkg;

  localparam int DBG_WORD_W = 10;

  typedef enum logic {
    DBG_IDLE  = 1'b0,
    DBG_SHIFT = 1'b1
  } dbg_state_t;

endpackage

// File: rtl/ym3438_dbg_deser.sv
// ym3438_dbg_deser
// Bit counter plus indexed shift register. A start on a step clears the
// register and begins a capture; bit 0 is taken on the following step.
// The step that writes bit DATA_WIDTH-1 raises o_done for that cycle, with
// o_word already holding the final bit merged in.
//
// State table:
//   DBG_IDLE  | waiting for a start
//   DBG_SHIFT | sampling one bit per step into r_sreg[r_cnt]
//
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_step         : chip-cycle enable; all state changes happen on steps
//   i_start        : (re)start a capture on this step
//   i_abort        : drop any capture in progress on this step
//   i_bit          : serial data, LSB first
//   o_busy         : capture in progress
//   o_done         : word completes on this edge
//   o_word         : shift register including the bit sampled this step
module ym3438_dbg_deser
  import ym3438_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = DBG_WORD_W,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_step,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_bit,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_word
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  dbg_state_t            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_sreg;
  logic [DATA_WIDTH-1:0] w_sreg_next;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_shift;

  assign w_start = i_step && i_start;
  // Start has priority over abort; both are only meaningful on a step.
  assign w_abort = i_step && !i_start && i_abort;
  assign w_shift = i_step && !i_start && !i_abort && (r_state == DBG_SHIFT);

  // Decoded write rather than a variable part-select keeps the index
  // width independent of DATA_WIDTH.
  always_comb begin
    w_sreg_next = r_sreg;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (r_cnt == CNT_WIDTH'(i)) begin
        w_sreg_next[i] = i_bit;
      end
    end
  end

  assign o_busy = (r_state == DBG_SHIFT);
  assign o_done = w_shift && (r_cnt == LAST_CNT);
  assign o_word = w_sreg_next;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= DBG_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else if (w_start) begin
      r_state <= DBG_SHIFT;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else if (w_abort) begin
      r_state <= DBG_IDLE;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_sreg <= w_sreg_next;
      if (r_cnt == LAST_CNT) begin
        r_state <= DBG_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ym3438_dbg_capture.sv
// ym3438_dbg_capture
// Tail of the debug serial read chain. Deserializes one word per load
// strobe and hands it to the test-register read mux with a valid/ack
// handshake and a sticky overrun flag.
//
// Ports:
//   MCLK       : master clock
//   IC         : synchronous active-low reset
//   c1         : chip-cycle phase-1 enable (defines a step)
//   c2         : chip-cycle phase-2 enable (reserved, not used for capture)
//   dbg_load   : copy of the chain load strobe
//   dbg_in     : serial chain data, LSB first
//   arm        : allows a load strobe to start a capture
//   ack        : host acknowledge pulse
//   data_out   : last stored word
//   data_valid : data_out holds an unacknowledged word
//   busy       : capture in progress
//   overrun    : a word completed while data_valid was set
module ym3438_dbg_capture
  import ym3438_dbg_pkg::*;
#(
  parameter int DATA_WIDTH = DBG_WORD_W,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  MCLK,
  input  logic                  IC,
  input  logic                  c1,
  input  logic                  c2,
  input  logic                  dbg_load,
  input  logic                  dbg_in,
  input  logic                  arm,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ovr;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_unused_c2;

  assign w_unused_c2 = c2;

  // A load strobe while unarmed aborts any running capture without
  // restarting; while armed it restarts from bit 0.
  ym3438_dbg_deser #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_deser (
    .i_clk   (MCLK),
    .i_rst_n (IC),
    .i_step  (c1),
    .i_start (dbg_load && arm),
    .i_abort (dbg_load && !arm),
    .i_bit   (dbg_in),
    .o_busy  (busy),
    .o_done  (w_done),
    .o_word  (w_word)
  );

  // A completion coinciding with ack is treated as if the ack landed just
  // before it: the new word is stored and no overrun is flagged.
  always_ff @(posedge MCLK) begin
    if (!IC) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_done) begin
      if (!r_valid || ack) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
        r_ovr   <= 1'b0;
      end else begin
        r_ovr <= 1'b1;
      end
    end else if (ack) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_ym3438_dbg_capture.sv
module tb_ym3438_dbg_capture;
  localparam int W = 10;

  logic         MCLK = 1'b0;
  logic         IC, c1, c2, dbg_load, dbg_in, arm, ack;
  logic [W-1:0] data_out;
  logic         data_valid, busy, overrun;

  int n_pass  = 0;
  int n_total = 0;

  ym3438_dbg_capture #(.DATA_WIDTH(W), .CNT_WIDTH(4)) dut (
    .MCLK       (MCLK),
    .IC         (IC),
    .c1         (c1),
    .c2         (c2),
    .dbg_load   (dbg_load),
    .dbg_in     (dbg_in),
    .arm        (arm),
    .ack        (ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a capture is a list of sampled bits; a word is
  // delivered once the list holds W bits.
  bit           m_started = 0;
  bit           m_capturing;
  bit           m_bits[$];
  logic [W-1:0] m_data;
  logic         m_valid, m_ovr;

  always @(posedge MCLK) begin
    bit           done;
    logic [W-1:0] word;
    done = 0;
    word = '0;
    m_started = 1;
    if (!IC) begin
      m_capturing = 0;
      m_bits.delete();
      m_data  = '0;
      m_valid = 0;
      m_ovr   = 0;
    end else begin
      if (c1) begin
        if (dbg_load) begin
          m_capturing = arm;
          m_bits.delete();
        end else if (m_capturing) begin
          m_bits.push_back(dbg_in);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) word[i] = m_bits[i];
            done = 1;
            m_capturing = 0;
            m_bits.delete();
          end
        end
      end
      if (done) begin
        if (m_valid && !ack) m_ovr = 1;
        else begin
          m_data  = word;
          m_valid = 1;
          m_ovr   = 0;
        end
      end else if (ack) begin
        m_valid = 0;
        m_ovr   = 0;
      end
    end
  end

  always @(negedge MCLK) begin
    if (m_started) begin
      chk("cmp_data_out", data_out, m_data);
      chk("cmp_data_valid", data_valid, m_valid);
      chk("cmp_busy", busy, m_capturing);
      chk("cmp_overrun", overrun, m_ovr);
    end
  end

  // One chip cycle: a c1 MCLK cycle followed by a c2 MCLK cycle.
  task automatic step(input logic ld, input logic din, input logic a);
    c1 = 1; c2 = 0; dbg_load = ld; dbg_in = din; ack = a;
    @(negedge MCLK);
    c1 = 0; c2 = 1; dbg_load = 0; ack = 0;
    @(negedge MCLK);
    c2 = 0;
  endtask

  task automatic ack_pulse();
    c1 = 0; c2 = 0; ack = 1;
    @(negedge MCLK);
    ack = 0;
  endtask

  task automatic capture(input logic [W-1:0] w, input logic ack_last);
    step(1, 0, 0);
    for (int i = 0; i < W; i++) step(0, w[i], (i == W - 1) ? ack_last : 1'b0);
  endtask

  initial begin
    IC = 0; c1 = 0; c2 = 0; dbg_load = 0; dbg_in = 0; arm = 0; ack = 0;
    repeat (3) @(negedge MCLK);
    chk("rst_data_out", data_out, 10'h000);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    IC = 1; arm = 1;
    @(negedge MCLK);

    // Basic capture.
    capture(10'h2A5, 0);
    chk("cap1_data", data_out, 10'h2A5);
    chk("cap1_valid", data_valid, 1'b1);
    chk("cap1_busy", busy, 1'b0);

    // Overrun, then ack.
    capture(10'h13C, 0);
    chk("ovr_data", data_out, 10'h2A5);
    chk("ovr_flag", overrun, 1'b1);
    ack_pulse();
    chk("ack_valid", data_valid, 1'b0);
    chk("ack_overrun", overrun, 1'b0);
    chk("ack_data_hold", data_out, 10'h2A5);

    // Completion with ack on the same edge while valid and overrun set.
    capture(10'h111, 0);
    capture(10'h222, 0);
    chk("pre_coinc_ovr", overrun, 1'b1);
    capture(10'h3FF, 1);
    chk("coinc_data", data_out, 10'h3FF);
    chk("coinc_valid", data_valid, 1'b1);
    chk("coinc_overrun", overrun, 1'b0);
    ack_pulse();

    // Restart by a second load at step 5.
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, (i % 2 == 0), 0);
    chk("mid_busy", busy, 1'b1);
    capture(10'h0F0, 0);
    chk("restart_data", data_out, 10'h0F0);
    chk("restart_valid", data_valid, 1'b1);
    chk("restart_ovr", overrun, 1'b0);
    ack_pulse();

    // arm dropped after the load does not abort.
    step(1, 0, 0);
    arm = 0;
    begin
      logic [W-1:0] w;
      w = 10'h2C3;
      for (int i = 0; i < W; i++) step(0, w[i], 0);
    end
    chk("armdrop_data", data_out, 10'h2C3);
    chk("armdrop_valid", data_valid, 1'b1);
    arm = 1;

    // Reset at step 7 of a capture.
    step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    IC = 0;
    step(0, 1, 0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_valid", data_valid, 1'b0);
    chk("midrst_data", data_out, 10'h000);
    IC = 1;
    capture(10'h0CC, 0);
    chk("postrst_data", data_out, 10'h0CC);
    chk("postrst_valid", data_valid, 1'b1);
    ack_pulse();

    // Unarmed load strobes start nothing.
    arm = 0;
    for (int i = 0; i < 50; i++) step(i % 3 == 0, i[0], 0);
    chk("unarmed_busy", busy, 1'b0);
    chk("unarmed_valid", data_valid, 1'b0);

    // Unarmed load during a capture aborts it.
    arm = 1;
    step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    arm = 0;
    step(1, 0, 0);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    chk("abort_valid", data_valid, 1'b0);
    chk("abort_data", data_out, 10'h0CC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ym3438_dbg_capture.md
Name: ym3438_dbg_capture

Overview:
- Receiving end of the debug serial read chain. The phase generator and sibling blocks load a parallel value into that chain on a strobe (fsm_sel2) and shift it out one bit per chip cycle.
- This block watches the chain tail, deserializes one word per strobe, and presents it to the test/host register interface with a valid/ack handshake and a sticky overrun flag.
- It sits between the end of the dbg_read chain and the test-register read mux.

Parameters:
- DATA_WIDTH, 10, number of bits captured per load strobe.
- CNT_WIDTH, 4, width of the bit counter; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- MCLK  input  1  master clock.
- IC  input  1  reset; synchronous to MCLK, active-low.
- c1  input  1  chip-cycle phase-1 enable; sampling happens on MCLK edges with c1=1.
- c2  input  1  chip-cycle phase-2 enable; unused for capture, reserved for phase checking; must not be high together with c1.
- dbg_load  input  1  copy of the chain's load strobe (fsm_sel2), sampled with c1.
- dbg_in  input  1  serial data from the chain tail, LSB first.
- arm  input  1  level; captures start only while arm=1.
- ack  input  1  host acknowledge, one MCLK pulse.
- data_out  output  DATA_WIDTH  captured word.
- data_valid  output  1  data_out holds an unacknowledged word.
- busy  output  1  a capture is in progress.
- overrun  output  1  sticky; a word completed while data_valid=1.

Behaviour:
- Step: an MCLK edge with c1=1. All state changes except ack handling occur only on steps.
- Reset (IC=0 at an MCLK edge) forces every output and all state to zero and the FSM to IDLE, including mid-capture. It overrides a simultaneous ack or step.
- FSM states:
  - IDLE: busy=0. A step with dbg_load=1 and arm=1 goes to SHIFT, with cnt=0 and the shift register cleared.
  - SHIFT: busy=1. Each step loads dbg_in into sreg bit cnt, then cnt increments. The step with cnt=DATA_WIDTH-1 goes to IDLE and completes the word.
- Bit alignment: bit 0 appears on dbg_in at the first step after the load step. The load step itself samples nothing.
- Capture latency: the word is complete DATA_WIDTH steps after the load step.
- Completion:
  - If data_valid=0: data_out <= sreg with the final bit merged; data_valid <= 1 on that same edge.
  - If data_valid=1: data_out is unchanged, the new word is dropped, and overrun <= 1.
- Load strobe during SHIFT: the current capture aborts with no completion. It restarts if arm=1, otherwise the FSM returns to IDLE.
- arm dropping during SHIFT does not abort; only the next load is gated.
- ack:
  - An MCLK edge with ack=1 clears data_valid; data_out holds its last value.
  - ack also clears overrun.
  - If ack and a completion occur on the same edge, the new word is stored and data_valid stays 1 with no overrun. Completion takes priority over ack.
- ack while data_valid=0 has no effect.
- Arithmetic: cnt is unsigned CNT_WIDTH bits and never exceeds DATA_WIDTH-1. There is no wrap-around by construction.

Decomposition:
- Shared package ym3438_dbg_pkg:
  - Constant DBG_WORD_W = 10.
  - FSM state enum {DBG_IDLE, DBG_SHIFT}.
- Sub-module ym3438_dbg_deser: counter plus indexed shift register with done pulse, reused by future wider chains.
- Top block: handshake, overrun and abort logic.

Test Plan:
- Reset, then IC=1, arm=1, load step, then serial bits for 0x2A5 LSB first over 10 steps -> data_valid=1 on the 10th step, data_out=0x2A5, busy=0.
- After the first word, a second word 0x13C completes without ack -> data_out stays 0x2A5 and overrun=1. Then ack -> data_valid=0 and overrun=0.
- ack on the exact edge where word 0x3FF completes while data_valid=1 -> data_out=0x3FF, data_valid=1, overrun=0.
- Load strobe again at step 5 of a capture of 0x155, then a full capture of 0x0F0 -> only 0x0F0 is delivered.
- IC=0 asserted at step 7 of a capture -> next edge shows busy=0, data_valid=0, data_out=0. A subsequent load captures normally.
- arm=0 with load strobes present -> busy stays 0 and data_valid stays 0 over 50 steps.
